intf: RTL and testbench
=======================

INTF -- requirements
Module: intf

Interface
REQ-001 PARAM, default 0, 32-bit instance parameter; bit 0 is the reset value of val; full value is reflected on param_id.
REQ-002 DEPTH, default 4, number of FIFO entries; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  producer offers in_data this cycle.
REQ-006 in_data  input  1  value offered by producer.
REQ-007 in_ready  output  1  FIFO can accept a value this cycle.
REQ-008 out_pop  input  1  consumer requests the next value be loaded into val.
REQ-009 val  output  1  current value presented to consumers, registered.
REQ-010 level  output  $clog2(DEPTH+1)  number of occupied FIFO entries.
REQ-011 full  output  1  level == DEPTH.
REQ-012 empty  output  1  level == 0.
REQ-013 param_id  output  32  constant equal to PARAM.
REQ-014 change_cnt  output  8  count of val value changes.

Function
REQ-015 The push SHALL occur on a rising edge when in_valid && in_ready; in_ready SHALL equal !full, combinationally.
REQ-016 The pop SHALL occur on a rising edge when out_pop && !empty; head entry is removed and val takes the head value from the next cycle on (1-cycle latency).
REQ-017 val SHALL hold its value on all cycles without a pop.
REQ-018 out_pop while empty SHALL be ignored: no state change, val held, even if a push occurs the same cycle (no bypass).
REQ-019 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-020 Simultaneous push and pop while full SHALL perform only the pop (in_ready is 0); level drops to DEPTH-1.
REQ-021 The FIFO SHALL be strictly first-in first-out; read/write pointers wrap modulo DEPTH without data loss.
REQ-022 A pop that loads a value different from the current val SHALL increment change_cnt by 1; change_cnt saturates at 255.
REQ-023 A pop loading a value equal to the current val SHALL NOT change change_cnt.
REQ-024 full, empty and level SHALL be derived from registered state with no combinational path from in_valid or out_pop.

Reset
REQ-025 On rst_n low, regardless of clk, the block SHALL clear level to 0, clear both pointers, set val = PARAM[0], and set change_cnt = 0.
REQ-026 Reset asserted mid-operation SHALL discard all FIFO contents; FIFO storage contents need not be cleared.
REQ-027 While rst_n is low, in_ready SHALL be 1, empty 1, full 0, param_id = PARAM.
REQ-028 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro INTF_CHANGE_CNT_EN: when defined, change_cnt SHALL behave per REQ-022/023.
REQ-030 When INTF_CHANGE_CNT_EN is undefined, change_cnt SHALL be tied to 0, no counter logic is built, and all other behaviour is unchanged.

Verification
REQ-031 PARAM=1, reset -> val=1, level=0, empty=1, param_id=1, change_cnt=0.
REQ-032 PARAM=0, DEPTH=4, push 1,0,1,1 -> full=1, in_ready=0; a 5th push is not accepted; pop four times -> val sequence 1,0,1,1, change_cnt=3, empty=1.
REQ-033 Level 2, push+pop same cycle -> level stays 2, order preserved; repeat 10 cycles -> pointer wrap with correct data.
REQ-034 Empty, push 1 with out_pop=1 same cycle -> val unchanged, level=1; next cycle pop -> val=1.
REQ-035 Alternating 0/1 for 300 pops -> change_cnt saturates at 255 (0 when INTF_CHANGE_CNT_EN is undefined).
REQ-036 rst_n pulsed low between clock edges with level 3 -> level=0 and val=PARAM[0] immediately, before the next edge.

Source files
------------

// File: rtl/intf_if.sv
// intf_if: producer/consumer FIFO port bundle; slave modport is the FIFO side, master the driving side.
interface intf_if #(parameter int DEPTH = 4) ();
    logic                       in_valid;
    logic                       in_data;
    logic                       in_ready;
    logic                       out_pop;
    logic                       val;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       full;
    logic                       empty;
    logic [31:0]                param_id;
    logic [7:0]                 change_cnt;
    modport slave (input in_valid, in_data, out_pop,
                   output in_ready, val, level, full, empty, param_id, change_cnt);
    modport master (output in_valid, in_data, out_pop,
                    input in_ready, val, level, full, empty, param_id, change_cnt);
endinterface

// File: rtl/intf.sv
// intf: 1-bit FIFO feeding a registered val output with a 1-cycle pop latency.
// Macro INTF_CHANGE_CNT_EN builds the saturating val-change counter; otherwise change_cnt is 0.
module intf #(
    parameter logic [31:0] PARAM = 32'd0,
    parameter int          DEPTH = 4
) (
    input logic   clk,
    input logic   rst_n,
    intf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             val_q, val_d;
    logic             full, empty, push, pop;

    // Flags come only from level_q, so in_valid/out_pop never reach them combinationally.
    assign full  = level_q == FULL_LVL;
    assign empty = level_q == '0;
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_pop && !empty;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = bus.in_data;
        wr_d    = push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
        level_d = level_q + LW'(push) - LW'(pop);
        val_d   = pop ? mem_q[rd_q] : val_q;
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            val_q   <= PARAM[0];
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            val_q   <= val_d;
        end
    end

`ifdef INTF_CHANGE_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb cnt_d = (pop && mem_q[rd_q] != val_q && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.change_cnt = cnt_q;
`else
    assign bus.change_cnt = 8'd0;
`endif

    assign bus.in_ready = !full;
    assign bus.val      = val_q;
    assign bus.level    = level_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.param_id = PARAM;
endmodule

// File: tb/tb_intf.sv
// tb_intf: directed checks of the intf FIFO with hand-computed expectations.
module tb_intf;
`ifdef INTF_CHANGE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    intf_if #(.DEPTH(4)) b0 ();
    intf_if #(.DEPTH(4)) b1 ();

    intf #(.PARAM(32'd0), .DEPTH(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    intf #(.PARAM(32'd1), .DEPTH(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic p);
        b0.in_valid = v;
        b0.in_data  = d;
        b0.out_pop  = p;
        @(posedge clk);
        @(negedge clk);
        b0.in_valid = 1'b0;
        b0.out_pop  = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        logic [3:0] fill;
        logic       q[$];
        logic       exp_val;
        b0.in_valid = 1'b0; b0.in_data = 1'b0; b0.out_pop = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = 1'b0; b1.out_pop = 1'b0;
        pat  = 10'b1101001011;
        fill = 4'b1101;

        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", b0.in_ready, 1);
        check("rst_empty", b0.empty, 1);
        check("rst_full", b0.full, 0);
        check("rst_level", b0.level, 0);
        check("rst_val0", b0.val, 0);
        check("rst_param_id0", b0.param_id, 0);
        check("rst_val1", b1.val, 1);
        check("rst_param_id1", b1.param_id, 1);
        check("rst_empty1", b1.empty, 1);
        check("rst_cnt1", b1.change_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // push 1,0,1,1 (fill read LSB first), first one right after reset release
        for (int i = 0; i < 4; i++) begin
            step(1'b1, fill[i], 1'b0);
            check("fill_level", b0.level, i + 1);
        end
        check("fill_full", b0.full, 1);
        check("fill_in_ready", b0.in_ready, 0);
        step(1'b1, 1'b0, 1'b0);
        check("push_when_full_level", b0.level, 4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check("drain_val", b0.val, fill[i]);
        end
        check("drain_cnt", b0.change_cnt, CNT_EN ? 3 : 0);
        check("drain_empty", b0.empty, 1);

        // pop while empty with a same-cycle push: no bypass
        step(1'b1, 1'b0, 1'b1);
        check("nobypass_val", b0.val, 1);
        check("nobypass_level", b0.level, 1);
        step(1'b0, 1'b0, 1'b1);
        check("nobypass_pop_val", b0.val, 0);
        check("nobypass_cnt", b0.change_cnt, CNT_EN ? 4 : 0);
        check("nobypass_empty", b0.empty, 1);

        // level 2 then 10 simultaneous push+pop cycles, wrapping the pointers
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        q.push_back(1'b1);
        q.push_back(1'b0);
        check("pp_level_start", b0.level, 2);
        for (int i = 0; i < 10; i++) begin
            q.push_back(pat[i]);
            exp_val = q.pop_front();
            step(1'b1, pat[i], 1'b1);
            check("pp_val", b0.val, exp_val);
            check("pp_level", b0.level, 2);
        end

        // fill to full, then push+pop while full performs only the pop
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("full_again", b0.full, 1);
        step(1'b1, 1'b0, 1'b1);
        check("full_pp_level", b0.level, 3);
        check("full_pp_val", b0.val, pat[8]);

        // asynchronous reset between edges with level 3
        #2 rst_n = 1'b0;
        #1;
        check("async_level", b0.level, 0);
        check("async_val", b0.val, 0);
        check("async_empty", b0.empty, 1);
        check("async_in_ready", b0.in_ready, 1);
        check("async_cnt", b0.change_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 300 alternating pops: val changes every pop, counter saturates
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, i[0] ? 1'b0 : 1'b1, 1'b1);
            if (i == 254) check("sat_cnt_254", b0.change_cnt, CNT_EN ? 254 : 0);
        end
        check("sat_cnt", b0.change_cnt, CNT_EN ? 255 : 0);
        check("sat_val", b0.val, 0);
        check("sat_level", b0.level, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
